bsg_unscan_stream: RTL and testbench

Streaming inverse of the XOR prefix scan. Each input word is one slice of a scanned bit-vector that may span several words. The block recovers the original (un-scanned) bits: o[j] = t[j] ^ t[adjacent], where t is the scanned input. The adjacent bit comes from the same word, or from the previous word of the same frame.
It sits on a valid/ready datapath between a scan-producing stage and its consumer. It is built on a 2-entry output buffer so it sustains one word per cycle.

---
 rtl/bsg_two_fifo.sv | 51 +++++
 rtl/bsg_unscan_stream.sv | 79 +++++++
 tb/tb_bsg_unscan_stream.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bsg_two_fifo.sv
// Two-entry in-order FIFO with valid/ready input and valid/yumi output.
// ready_o depends only on registered occupancy, never on yumi_i.
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               head_r;
    logic               tail_r;
    logic [1:0]         count_r;
    logic               enq;
    logic               deq;

    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign ready_o = (count_r != 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign data_o  = mem_r[head_r];

    // Pointer and occupancy tracking; enqueue+dequeue together leaves count unchanged
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (enq) tail_r <= ~tail_r;
            if (deq) head_r <= ~head_r;
            case ({enq, deq})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage write; contents are don't-care while the slot is empty
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[tail_r] <= data_i;
    end

endmodule

// File: rtl/bsg_unscan_stream.sv
// Streaming inverse of an XOR prefix scan across multi-word frames.
// Each output bit is the scanned bit XOR its neighbour toward the scan origin;
// the neighbour of the word's origin-side edge bit is carried from the previous word.
module bsg_unscan_stream #(
    parameter int width_p    = 8,
    parameter bit lo_to_hi_p = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               last_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               last_o,
    input  logic               yumi_i
);

    logic               carry_r;
    logic               frame_start_r;
    logic               carry_eff;
    logic               accept;
    logic               boundary_bit;
    logic [width_p-1:0] neighbor;
    logic [width_p-1:0] unscan;

    assign accept    = v_i & ready_o;
    // carry_r is already zero at frame start; masking keeps that explicit
    assign carry_eff = carry_r & ~frame_start_r;

    generate
        if (width_p == 1) begin : g_single
            assign neighbor     = carry_eff;
            assign boundary_bit = data_i[0];
        end else if (lo_to_hi_p) begin : g_lo_to_hi
            assign neighbor     = {data_i[width_p-2:0], carry_eff};
            assign boundary_bit = data_i[width_p-1];
        end else begin : g_hi_to_lo
            assign neighbor     = {carry_eff, data_i[width_p-1:1]};
            assign boundary_bit = data_i[0];
        end
    endgenerate

    assign unscan = data_i ^ neighbor;

    // Carry the far-edge scanned bit into the next word; cleared at frame end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            carry_r       <= 1'b0;
            frame_start_r <= 1'b1;
        end else if (accept) begin
            carry_r       <= last_i ? 1'b0 : boundary_bit;
            frame_start_r <= last_i;
        end
    end

    bsg_two_fifo #(
        .width_p(width_p + 1)
    ) fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .ready_o(ready_o),
        .data_i ({last_i, unscan}),
        .v_i    (v_i),
        .v_o    (v_o),
        .data_o ({last_o, data_o}),
        .yumi_i (yumi_i)
    );

    // Consumer must only take a word that is being offered
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
                else $error("bsg_unscan_stream: yumi_i asserted while v_o low");
        end
    end

endmodule

// File: tb/tb_bsg_unscan_stream.sv
// Directed bench: 4-bit hi->lo, 4-bit lo->hi and 1-bit instances.
module tb_bsg_unscan_stream;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // instance A: width 4, hi->lo
    logic       a_v = 1'b0, a_last = 1'b0, a_take = 1'b1;
    logic [3:0] a_data = '0;
    logic       a_ready, a_v_o, a_last_o, a_yumi;
    logic [3:0] a_data_o;
    assign a_yumi = a_v_o & a_take;

    // instance B: width 4, lo->hi
    logic       b_v = 1'b0, b_last = 1'b0;
    logic [3:0] b_data = '0;
    logic       b_ready, b_v_o, b_last_o, b_yumi;
    logic [3:0] b_data_o;
    assign b_yumi = b_v_o;

    // instance C: width 1
    logic       c_v = 1'b0, c_last = 1'b0;
    logic [0:0] c_data = '0;
    logic       c_ready, c_v_o, c_last_o, c_yumi;
    logic [0:0] c_data_o;
    assign c_yumi = c_v_o;

    bsg_unscan_stream #(.width_p(4), .lo_to_hi_p(1'b0)) dut_a (
        .clk_i(clk), .reset_i(reset), .v_i(a_v), .data_i(a_data), .last_i(a_last),
        .ready_o(a_ready), .v_o(a_v_o), .data_o(a_data_o), .last_o(a_last_o), .yumi_i(a_yumi));

    bsg_unscan_stream #(.width_p(4), .lo_to_hi_p(1'b1)) dut_b (
        .clk_i(clk), .reset_i(reset), .v_i(b_v), .data_i(b_data), .last_i(b_last),
        .ready_o(b_ready), .v_o(b_v_o), .data_o(b_data_o), .last_o(b_last_o), .yumi_i(b_yumi));

    bsg_unscan_stream #(.width_p(1), .lo_to_hi_p(1'b0)) dut_c (
        .clk_i(clk), .reset_i(reset), .v_i(c_v), .data_i(c_data), .last_i(c_last),
        .ready_o(c_ready), .v_o(c_v_o), .data_o(c_data_o), .last_o(c_last_o), .yumi_i(c_yumi));

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
            else begin
                n_err++;
                $error("FAIL %s: observed %b expected %b", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [3:0] d, input logic l);
        a_v = 1'b1; a_data = d; a_last = l;
        tick();
        a_v = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] d, input logic l);
        b_v = 1'b1; b_data = d; b_last = l;
        tick();
        b_v = 1'b0;
    endtask

    task automatic send_c(input logic d, input logic l);
        c_v = 1'b1; c_data = d; c_last = l;
        tick();
        c_v = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        tick();

        // reset state
        chk("a_rst_v", {3'b0, a_v_o}, 4'd0);
        chk("a_rst_ready", {3'b0, a_ready}, 4'd1);
        chk("b_rst_v", {3'b0, b_v_o}, 4'd0);
        chk("c_rst_ready", {3'b0, c_ready}, 4'd1);

        // single-word frame
        send_a(4'b1010, 1'b1);
        chk("a_single_v", {3'b0, a_v_o}, 4'd1);
        chk("a_single_data", a_data_o, 4'b1111);
        chk("a_single_last", {3'b0, a_last_o}, 4'd1);

        // two-word frame with carry
        send_a(4'b0000, 1'b0);
        chk("a_two_w0", a_data_o, 4'b0000);
        chk("a_two_w0_last", {3'b0, a_last_o}, 4'd0);
        send_a(4'b1111, 1'b1);
        chk("a_two_w1", a_data_o, 4'b1000);
        chk("a_two_w1_last", {3'b0, a_last_o}, 4'd1);

        // frame boundary clears carry, full rate back-to-back
        send_a(4'b1111, 1'b1);
        chk("a_bound_0", a_data_o, 4'b1000);
        send_a(4'b1111, 1'b1);
        chk("a_bound_1", a_data_o, 4'b1000);
        chk("a_rate_v", {3'b0, a_v_o}, 4'd1);
        send_a(4'b1111, 1'b0);
        chk("a_bound_2", a_data_o, 4'b1000);
        send_a(4'b1111, 1'b1);
        chk("a_bound_3", a_data_o, 4'b0000);
        tick();
        chk("a_drained_v", {3'b0, a_v_o}, 4'd0);

        // backpressure
        a_take = 1'b0;
        a_v = 1'b1; a_data = 4'b0000; a_last = 1'b0;
        tick();
        chk("a_bp_ready1", {3'b0, a_ready}, 4'd1);
        a_data = 4'b1111; a_last = 1'b0;
        tick();
        chk("a_bp_full", {3'b0, a_ready}, 4'd0);
        chk("a_bp_head", a_data_o, 4'b0000);
        a_data = 4'b0011; a_last = 1'b1;
        tick();
        chk("a_bp_hold_ready", {3'b0, a_ready}, 4'd0);
        chk("a_bp_hold_head", a_data_o, 4'b0000);
        a_take = 1'b1;
        tick();
        chk("a_bp_drain1", a_data_o, 4'b1000);
        chk("a_bp_ready2", {3'b0, a_ready}, 4'd1);
        tick();
        a_v = 1'b0;
        chk("a_bp_drain2", a_data_o, 4'b1010);
        chk("a_bp_drain2_last", {3'b0, a_last_o}, 4'd1);
        tick();
        chk("a_bp_empty", {3'b0, a_v_o}, 4'd0);

        // reset mid-frame
        a_take = 1'b0;
        send_a(4'b1111, 1'b0);
        chk("a_mid_v", {3'b0, a_v_o}, 4'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("a_mid_rst_v", {3'b0, a_v_o}, 4'd0);
        chk("a_mid_rst_ready", {3'b0, a_ready}, 4'd1);
        a_take = 1'b1;
        send_a(4'b1111, 1'b1);
        chk("a_mid_after", a_data_o, 4'b1000);

        // lo->hi instance
        send_b(4'b0101, 1'b1);
        chk("b_single", b_data_o, 4'b1111);
        send_b(4'b1111, 1'b0);
        chk("b_two_w0", b_data_o, 4'b0001);
        send_b(4'b1111, 1'b1);
        chk("b_two_w1", b_data_o, 4'b0000);
        chk("b_two_w1_last", {3'b0, b_last_o}, 4'd1);

        // width 1 instance
        send_c(1'b1, 1'b0);
        chk("c_w0", {3'b0, c_data_o}, 4'd1);
        send_c(1'b1, 1'b1);
        chk("c_w1", {3'b0, c_data_o}, 4'd0);
        send_c(1'b1, 1'b1);
        chk("c_w2", {3'b0, c_data_o}, 4'd1);
        send_c(1'b0, 1'b1);
        chk("c_w3", {3'b0, c_data_o}, 4'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
